variable_flip_selector: RTL and testbench
=========================================

// Module: variable_flip_selector
// PURPOSE
//  WalkSAT flip-variable chooser. Computes a break value for each of NSAT candidate literals
//  of a chosen unsatisfied clause, streamed one per cycle. Then picks the variable to flip:
//  zero-break override, greedy minimum, or random walk.
//  Sits between the clause-status fetch and the variable-flip/update stage.
// PARAMETERS
//  MAX_CLAUSES_PER_VARIABLE       20           clause-status bits per candidate (MC)
//  NSAT                           3            candidates per clause (k of k-SAT)
//  MAX_CLAUSES_PER_VARIABLE_BITS  5            break-value width (MCB); must hold MC
//  NSAT_BITS                      2            candidate index width
//  P                              32'h6E147AE0 greedy/random threshold on random_i
// PORTS
//  clk                   in   1       clock, all logic on rising edge
//  reset                 in   1       synchronous, active-high
//  clause_broken_i       in   MC      per-clause "would break if flipped" bits, current candidate
//  mask_bits_i           in   MC      per-clause valid mask, current candidate
//  break_values_valid_i  in   NSAT    per-candidate valid flags, sampled on the final cycle
//  random_i              in   32      random word, sampled on the final cycle
//  wren_i                in   NSAT_BITS  0=idle; k (1..NSAT) = candidate k-1 on inputs
//  selected_o            out  NSAT_BITS  registered index of the variable to flip
//  clause_broken_bits_o  out  MC      registered masked broken bits of the selected candidate
// BEHAVIOUR
//  - Break value bv[k] = popcount(clause_broken_i & mask_bits_i), MCB bits (max MC, no overflow).
//  - wren_i=k for 1<=k<NSAT: at the clock edge, store bv[k-1] in break_values_reg[k-1].
//    Also store the masked bits in break_bits_reg[k-1].
//  - wren_i=NSAT (final cycle):
//    - Candidate NSAT-1 is used combinationally from the live inputs.
//    - Form all_break_values = {bv[NSAT-1], reg[NSAT-2..0]}, packed with MCB*n as the LSB of candidate n.
//    - Decide; register selected_o and clause_broken_bits_o at this same edge.
//    - The result is visible the cycle after wren_i=NSAT; inputs may be X from then on.
//  - Decision, for candidates with break_values_valid_i[n]=1:
//    1. Zero override: any valid bv==0 -> select the HIGHEST index with bv==0.
//       random_i is ignored in this case.
//    2. Else if random_i < P (unsigned) -> greedy: select the minimum bv.
//       Tie priority order is 1,2,...,NSAT-1,0; earlier in that order wins, so candidate 0 loses all ties.
//    3. Else (random_i >= P) -> random walk: select random_i[5:0] % NSAT.
//    - No candidate valid -> select 0.
//  - clause_broken_bits_o = the stored/live (clause_broken & mask) of the selected candidate.
//  - wren_i=0 or wren_i>NSAT: no register update; outputs hold their last decision.
//  - Reset: selected_o=0, clause_broken_bits_o=0, all break_values_reg/break_bits_reg=0.
//    Reset wins over a coincident wren_i.
//  - Registers 0..NSAT-2 are overwritten by each new sequence; no clearing between sequences.
//  - Internal arrays break_values_reg[0:NSAT-2], break_bits_reg[0:NSAT-2] and the
//    all_break_values vector keep these names for hierarchical monitoring.
// TESTING
//  Sequence per test: wren 0,1,2,3 on successive cycles, valid=3'b111 on wren=3; check one cycle later.
//  - All three candidates mask=0 -> selected_o=2, clause_broken_bits_o=0.
//  - Only candidate j has bv=0 (others have bit9 set in both vectors), any random_i
//    -> selected_o=j, bits=0; check j=0,1,2.
//  - Zeros at {1,2}->2; {0,2}->2; {0,1}->1; bits = selected candidate's masked bits.
//  - random_i=0, candidate j has bv=1 (bit9 only), others have bits 9,10 set
//    -> selected_o=j, bits=20'h00200.
//  - random_i=0 with ties: bv=1 at {1,2}->1; {0,2}->2; {0,1}->1.
//  - All bv nonzero, random_i=32'hFF000000+j for j=0..8 -> selected_o=j%3, bits=masked bits of it.

Source files
------------

// File: rtl/variable_flip_selector.sv
// WalkSAT flip-variable chooser: accumulates per-candidate break values over a
// streamed clause, then registers the index and masked broken bits of the variable to flip.
module variable_flip_selector #(
  parameter int          MAX_CLAUSES_PER_VARIABLE      = 20,
  parameter int          NSAT                          = 3,
  parameter int          MAX_CLAUSES_PER_VARIABLE_BITS = 5,
  parameter int          NSAT_BITS                     = 2,
  parameter logic [31:0] P                             = 32'h6E147AE0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_bits_i,
  input  logic [NSAT-1:0]                     break_values_valid_i,
  input  logic [31:0]                         random_i,
  input  logic [NSAT_BITS-1:0]                wren_i,
  output logic [NSAT_BITS-1:0]                selected_o,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_bits_o
);

  localparam int MC  = MAX_CLAUSES_PER_VARIABLE;
  localparam int MCB = MAX_CLAUSES_PER_VARIABLE_BITS;

  function automatic logic [MCB-1:0] popcount(input logic [MC-1:0] v);
    logic [MCB-1:0] c;
    c = '0;
    for (int i = 0; i < MC; i++) c = c + MCB'(v[i]);
    return c;
  endfunction

  logic [MCB-1:0]       break_values_reg [0:NSAT-2];
  logic [MC-1:0]        break_bits_reg   [0:NSAT-2];
  logic [MCB*NSAT-1:0]  all_break_values;

  logic [MC-1:0]        masked_live;
  logic [MCB-1:0]       bv_live;
  logic                 any_zero;
  logic [NSAT_BITS-1:0] zero_idx;
  logic                 greedy_found;
  logic [MCB-1:0]       greedy_bv;
  logic [NSAT_BITS-1:0] greedy_idx;
  logic [NSAT_BITS-1:0] walk_idx;
  logic [NSAT_BITS-1:0] selected_d, selected_q;
  logic [MC-1:0]        bits_d, bits_q;

  assign masked_live = clause_broken_i & mask_bits_i;
  assign bv_live     = popcount(masked_live);
  assign walk_idx    = NSAT_BITS'(32'(random_i[5:0]) % 32'(NSAT));

  always_comb begin
    all_break_values = '0;
    for (int n = 0; n < NSAT - 1; n++) all_break_values[n*MCB +: MCB] = break_values_reg[n];
    all_break_values[(NSAT-1)*MCB +: MCB] = bv_live;
  end

  always_comb begin
    any_zero     = 1'b0;
    zero_idx     = '0;
    greedy_found = 1'b0;
    greedy_bv    = '0;
    greedy_idx   = '0;
    selected_d   = '0;
    bits_d       = masked_live;
    // Ascending scan so the highest zero-break index is the one left standing.
    for (int n = 0; n < NSAT; n++) begin
      if (break_values_valid_i[n] && all_break_values[n*MCB +: MCB] == '0) begin
        any_zero = 1'b1;
        zero_idx = NSAT_BITS'(n);
      end
    end
    // Visit candidates in tie-priority order 1..NSAT-1,0; strict < keeps the earliest.
    for (int i = 0; i < NSAT; i++) begin
      int n;
      n = (i == NSAT - 1) ? 0 : i + 1;
      if (break_values_valid_i[n] &&
          (!greedy_found || all_break_values[n*MCB +: MCB] < greedy_bv)) begin
        greedy_found = 1'b1;
        greedy_bv    = all_break_values[n*MCB +: MCB];
        greedy_idx   = NSAT_BITS'(n);
      end
    end
    if (break_values_valid_i == '0) selected_d = '0;
    else if (any_zero)              selected_d = zero_idx;
    else if (random_i < P)          selected_d = greedy_idx;
    else                            selected_d = walk_idx;
    for (int n = 0; n < NSAT - 1; n++) begin
      if (selected_d == NSAT_BITS'(n)) bits_d = break_bits_reg[n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      selected_q <= '0;
      bits_q     <= '0;
      for (int n = 0; n < NSAT - 1; n++) begin
        break_values_reg[n] <= '0;
        break_bits_reg[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < NSAT - 1; n++) begin
        if (wren_i == NSAT_BITS'(n + 1)) begin
          break_values_reg[n] <= bv_live;
          break_bits_reg[n]   <= masked_live;
        end
      end
      if (wren_i == NSAT_BITS'(NSAT)) begin
        selected_q <= selected_d;
        bits_q     <= bits_d;
      end
    end
  end

  assign selected_o           = selected_q;
  assign clause_broken_bits_o = bits_q;

endmodule

// File: tb/tb_variable_flip_selector.sv
// Bench for variable_flip_selector: directed cases with fixed expectations plus
// randomized sequences scored against a behavioural model of the selection rules.
module tb_variable_flip_selector;

  localparam logic [31:0] P = 32'h6E147AE0;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] clause_broken_i, mask_bits_i;
  logic [2:0]  break_values_valid_i;
  logic [31:0] random_i;
  logic [1:0]  wren_i;
  logic [1:0]  selected_o;
  logic [19:0] clause_broken_bits_o;

  logic [19:0] tb_br [3];
  logic [19:0] tb_mk [3];
  logic [21:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  variable_flip_selector dut (
    .clk(clk), .reset(reset),
    .clause_broken_i(clause_broken_i), .mask_bits_i(mask_bits_i),
    .break_values_valid_i(break_values_valid_i), .random_i(random_i),
    .wren_i(wren_i), .selected_o(selected_o), .clause_broken_bits_o(clause_broken_bits_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic garbage_inputs();
    clause_broken_i      = 20'($urandom);
    mask_bits_i          = 20'($urandom);
    break_values_valid_i = 3'($urandom);
    random_i             = $urandom;
  endtask

  // Behavioural reference: selection rules applied directly to the candidate table.
  function automatic void model(input logic [2:0] vld, input logic [31:0] rnd,
                                output logic [1:0] sel, output logic [19:0] bits);
    int bv [3];
    int order [3] = '{1, 2, 0};
    int best;
    bit zero_seen;
    for (int n = 0; n < 3; n++) bv[n] = $countones(tb_br[n] & tb_mk[n]);
    sel = 2'd0;
    zero_seen = 0;
    for (int n = 2; n >= 0; n--) begin
      if (vld[n] && bv[n] == 0 && !zero_seen) begin
        sel = 2'(n);
        zero_seen = 1;
      end
    end
    if (vld == 3'b000) sel = 2'd0;
    else if (!zero_seen) begin
      if (rnd < P) begin
        best = 1000;
        foreach (order[i]) begin
          if (vld[order[i]] && bv[order[i]] < best) begin
            best = bv[order[i]];
            sel  = 2'(order[i]);
          end
        end
      end else begin
        sel = 2'(rnd[5:0] % 3);
      end
    end
    bits = tb_br[sel] & tb_mk[sel];
  endfunction

  task automatic run_seq(input string tag, input logic [2:0] vld, input logic [31:0] rnd,
                         input logic [1:0] e_sel, input logic [19:0] e_bits);
    logic [21:0] e;
    exp_q.push_back({e_sel, e_bits});
    @(posedge clk); #1;
    wren_i = 2'd0;
    garbage_inputs();
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      wren_i          = 2'(k);
      clause_broken_i = tb_br[k-1];
      mask_bits_i     = tb_mk[k-1];
      if (k == 3) begin
        break_values_valid_i = vld;
        random_i             = rnd;
      end else begin
        break_values_valid_i = 3'($urandom);
        random_i             = $urandom;
      end
    end
    @(posedge clk); #1;
    wren_i = 2'd0;
    garbage_inputs();
    e = exp_q.pop_front();
    check({tag, "_sel"}, 32'(selected_o), 32'(e[21:20]));
    check({tag, "_bits"}, 32'(clause_broken_bits_o), 32'(e[19:0]));
    @(posedge clk); #1;
    garbage_inputs();
    check({tag, "_hold"}, 32'({selected_o, clause_broken_bits_o}), 32'(e));
  endtask

  task automatic set_cands(input logic [19:0] b0, m0, b1, m1, b2, m2);
    tb_br[0] = b0; tb_mk[0] = m0;
    tb_br[1] = b1; tb_mk[1] = m1;
    tb_br[2] = b2; tb_mk[2] = m2;
  endtask

  initial begin
    logic [1:0]  m_sel;
    logic [19:0] m_bits;
    logic [19:0] r;
    int zp [3][2] = '{'{1, 2}, '{0, 2}, '{0, 1}};
    int zexp [3]  = '{2, 2, 1};

    reset  = 1'b1;
    wren_i = 2'd0;
    garbage_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_sel", 32'(selected_o), 32'd0);
    check("reset_bits", 32'(clause_broken_bits_o), 32'd0);
    check("reset_bv0", 32'(dut.break_values_reg[0]), 32'd0);
    check("reset_bb1", 32'(dut.break_bits_reg[1]), 32'd0);
    reset = 1'b0;

    set_cands(20'($urandom), 20'h0, 20'($urandom), 20'h0, 20'($urandom), 20'h0);
    run_seq("all_masked", 3'b111, $urandom, 2'd2, 20'h0);

    for (int j = 0; j < 3; j++) begin
      set_cands(20'h00200, 20'h00200, 20'h00200, 20'h00200, 20'h00200, 20'h00200);
      r = 20'($urandom);
      tb_br[j] = r; tb_mk[j] = ~r;
      run_seq($sformatf("single_zero%0d", j), 3'b111, $urandom, 2'(j), 20'h0);
    end

    for (int p = 0; p < 3; p++) begin
      set_cands(20'h00200, 20'h00200, 20'h00200, 20'h00200, 20'h00200, 20'h00200);
      foreach (zp[p][q]) begin tb_br[zp[p][q]] = 20'h00400; tb_mk[zp[p][q]] = 20'h00800; end
      run_seq($sformatf("zero_pair%0d", p), 3'b111, $urandom, 2'(zexp[p]), 20'h0);
    end

    for (int j = 0; j < 3; j++) begin
      set_cands(20'h00600, 20'h00600, 20'h00600, 20'h00600, 20'h00600, 20'h00600);
      tb_br[j] = 20'h00200; tb_mk[j] = 20'h00200;
      run_seq($sformatf("greedy_min%0d", j), 3'b111, 32'd0, 2'(j), 20'h00200);
    end

    for (int p = 0; p < 3; p++) begin
      set_cands(20'h00600, 20'h00600, 20'h00600, 20'h00600, 20'h00600, 20'h00600);
      foreach (zp[p][q]) begin tb_br[zp[p][q]] = 20'h00200; tb_mk[zp[p][q]] = 20'h00200; end
      run_seq($sformatf("greedy_tie%0d", p), 3'b111, 32'd0,
              (p == 1) ? 2'd2 : 2'd1, 20'h00200);
    end

    set_cands(20'h00001, 20'hFFFFF, 20'h00003, 20'hFFFFF, 20'h00007, 20'hFFFFF);
    for (int j = 0; j < 9; j++) begin
      run_seq($sformatf("walk%0d", j), 3'b111, 32'hFF000000 + 32'(j), 2'(j % 3),
              (j % 3 == 0) ? 20'h00001 : (j % 3 == 1) ? 20'h00003 : 20'h00007);
    end
    run_seq("p_minus1", 3'b111, P - 32'd1, 2'd0, 20'h00001);
    run_seq("p_exact", 3'b111, P, 2'd2, 20'h00007);
    run_seq("none_valid", 3'b000, 32'hFFFFFFFF, 2'd0, 20'h00001);

    set_cands(20'h00001, 20'h00001, 20'h00003, 20'h00003, 20'h00000, 20'hFFFFF);
    run_seq("zero_invalid", 3'b011, 32'd0, 2'd0, 20'h00001);

    set_cands(20'hFFFFF, 20'hFFFFF, 20'hFFFFE, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
    run_seq("max_pop", 3'b111, 32'd0, 2'd1, 20'hFFFFE);

    // Reset coinciding with the final write must win and clear everything.
    set_cands(20'h00005, 20'h00005, 20'h00003, 20'h00003, 20'h00001, 20'h00001);
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      wren_i = 2'(k); clause_broken_i = tb_br[k-1]; mask_bits_i = tb_mk[k-1];
      break_values_valid_i = 3'b111; random_i = 32'd0;
      if (k == 3) reset = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b0; wren_i = 2'd0;
    check("rst_win_sel", 32'(selected_o), 32'd0);
    check("rst_win_bits", 32'(clause_broken_bits_o), 32'd0);
    check("rst_win_bv0", 32'(dut.break_values_reg[0]), 32'd0);
    check("rst_win_bb1", 32'(dut.break_bits_reg[1]), 32'd0);

    for (int t = 0; t < 200; t++) begin
      logic [2:0]  vld;
      logic [31:0] rnd;
      for (int n = 0; n < 3; n++) begin
        tb_br[n] = 20'($urandom) & 20'($urandom);
        tb_mk[n] = ($urandom_range(0, 3) == 0) ? 20'h0 : 20'($urandom) & 20'($urandom);
      end
      vld = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      rnd = $urandom;
      model(vld, rnd, m_sel, m_bits);
      run_seq($sformatf("rand%0d", t), vld, rnd, m_sel, m_bits);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
